// File: rtl/alu_input_seq_pkg.sv
// Shared ALU definitions: input-sequencer FSM states and ALU opcode constants.
package alu_input_seq_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } seq_state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  function automatic seq_state_t next_state(input seq_state_t s);
    case (s)
      S_A:     return S_B;
      S_B:     return S_OP;
      S_OP:    return S_RUN;
      default: return S_A;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounces a synchronized button level and emits a one-cycle pulse on each
// accepted rising transition of the stable level.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic press
);

  localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

  logic        stable;
  logic [15:0] cnt;

  // Toggle happens on the DB_CYCLES-th differing sample; >= keeps the counter
  // from ever running past the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_sync == stable) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
        press  <= ~stable;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/alu_input_seq.sv
// Step-button driven entry of ALU operands A, B and opcode from a 4-bit switch.
module alu_input_seq
  import alu_input_seq_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       step_btn,
  input  logic       clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic       op_valid,
  output logic [1:0] phase
);

  logic       step_meta, step_sync;
  logic [3:0] sw_meta, sw_sync;
  logic       press;
  seq_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      step_meta <= step_btn;
      step_sync <= step_meta;
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
    end
  end

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_sync(step_sync),
    .press   (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_A;
      a        <= '0;
      b        <= '0;
      op       <= '0;
      op_valid <= 1'b0;
    end else if (clr) begin
      state    <= S_A;
      a        <= '0;
      b        <= '0;
      op       <= '0;
      op_valid <= 1'b0;
    end else if (press) begin
      case (state)
        S_A:     a  <= sw_sync;
        S_B:     b  <= sw_sync;
        S_OP:    op <= sw_sync[2:0];
        default: ;
      endcase
      state    <= next_state(state);
      op_valid <= (next_state(state) == S_RUN);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_alu_input_seq.sv
// Randomized scoreboard bench for alu_input_seq with DB_CYCLES=4.
module tb_alu_input_seq;
  import alu_input_seq_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned LAT = DB + 3;  // raw rise -> visible output update

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic       step_btn = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] a, b;
  logic [2:0] op;
  logic       op_valid;
  logic [1:0] phase;

  alu_input_seq #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .step_btn(step_btn), .clr(clr),
    .a(a), .b(b), .op(op), .op_valid(op_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [13:0] val;
  } exp_t;

  exp_t        q[$];
  logic [13:0] rq[$];
  bit          done = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: operation entry as a phase counter modulo 4.
  int unsigned m_a = 0, m_b = 0, m_op = 0, m_ph = 0;

  function automatic logic [13:0] mval();
    logic [3:0] ta, tb;
    logic [2:0] to;
    logic [1:0] tp;
    ta = 4'(m_a); tb = 4'(m_b); to = 3'(m_op); tp = 2'(m_ph);
    return {ta, tb, to, (m_ph == 3) ? 1'b1 : 1'b0, tp};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_if_changed(input int unsigned c, input logic [13:0] old);
    exp_t e;
    if (mval() != old) begin
      e.cyc = c;
      e.val = mval();
      q.push_back(e);
    end
  endtask

  task automatic model_press(input logic [3:0] s);
    case (m_ph)
      0: m_a = s;
      1: m_b = s;
      2: m_op = s % 8;
      default: ;
    endcase
    m_ph = (m_ph + 1) % 4;
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_ph = 0;
  endtask

  task automatic do_press(input logic [3:0] s, input int unsigned hold,
                          input int unsigned gap, input bit with_clr);
    logic [13:0] old;
    int unsigned r;
    old = mval();
    sw = s;
    step_btn = 1'b1;
    r = cyc;
    if (with_clr) model_clear();
    else model_press(s);
    push_if_changed(r + LAT, old);
    if (with_clr) begin
      tick(LAT - 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(hold - LAT);
    end else begin
      tick(hold);
    end
    step_btn = 1'b0;
    tick(gap);
  endtask

  task automatic do_clr();
    logic [13:0] old;
    old = mval();
    clr = 1'b1;
    model_clear();
    push_if_changed(cyc + 1, old);
    tick(1);
    clr = 1'b0;
    tick(2);
  endtask

  task automatic do_glitch(input int unsigned k);
    step_btn = 1'b1;
    tick(k);
    step_btn = 1'b0;
    tick(8);
  endtask

  // Pulse rst between clock edges and snapshot outputs while it is high.
  task automatic do_async_reset();
    logic [13:0] old;
    old = mval();
    rst = 1'b1;
    #1;
    rq.push_back({a, b, op, op_valid, phase});
    #1;
    rst = 1'b0;
    model_clear();
    push_if_changed(cyc, old);
    tick(2);
  endtask

  initial begin : stimulus
    logic [13:0] old;
    int unsigned r;
    repeat (3) @(posedge clk);
    #2;
    rq.push_back({a, b, op, op_valid, phase});
    rst = 1'b0;
    tick(3);

    // Full entry then wrap back to S_A.
    do_press(4'd3, 8, 8, 1'b0);
    do_press(4'd5, 8, 8, 1'b0);
    do_press(4'b0001, 8, 8, 1'b0);
    do_press(4'd12, 8, 8, 1'b0);

    // Opcode masking.
    do_press(4'd7, 9, 8, 1'b0);
    do_press(4'd2, 8, 9, 1'b0);
    do_press(4'b1110, 8, 8, 1'b0);
    do_press(4'd0, 8, 8, 1'b0);

    // Clear colliding with a press in S_OP.
    do_press(4'd9, 8, 8, 1'b0);
    do_press(4'd4, 8, 8, 1'b0);
    do_press(4'd6, 10, 8, 1'b1);

    // Async reset in S_B, then restart at S_A.
    do_press(4'd11, 8, 8, 1'b0);
    do_async_reset();
    do_press(4'd9, 8, 8, 1'b0);

    // Bounce: 2-cycle toggles for 20 cycles, then hold high.
    sw = 4'd13;
    for (int unsigned i = 0; i < 10; i++) begin
      step_btn = (i % 2 == 0);
      tick(2);
    end
    old = mval();
    step_btn = 1'b1;
    r = cyc;
    model_press(4'd13);
    push_if_changed(r + LAT, old);
    tick(12);
    step_btn = 1'b0;
    tick(10);

    // Button held through reset release.
    sw = 4'd10;
    step_btn = 1'b1;
    old = mval();
    rst = 1'b1;
    #1;
    rq.push_back({a, b, op, op_valid, phase});
    model_clear();
    push_if_changed(cyc, old);
    tick(3);
    rst = 1'b0;
    r = cyc;
    old = mval();
    model_press(4'd10);
    push_if_changed(r + LAT, old);
    tick(30);
    step_btn = 1'b0;
    tick(10);

    // Randomized mix.
    for (int unsigned i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: do_glitch($urandom_range(1, DB - 1));
        1: do_clr();
        2: do_async_reset();
        default: do_press(4'($urandom_range(0, 15)), $urandom_range(8, 12),
                          $urandom_range(8, 12), 1'b0);
      endcase
    end
    tick(10);
    done = 1'b1;
  end

  initial begin : monitor
    logic [13:0] prev, cur, s;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      while (rq.size() > 0) begin
        s = rq.pop_front();
        n_vec++;
        if (s != '0) begin
          n_err++;
          $display("FAIL async_reset cyc=%0d got=%h exp=0", cyc, s);
        end
      end
      cur = {a, b, op, op_valid, phase};
      if (cur != prev) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_update cyc=%0d got=%h was=%h", cyc, cur, prev);
        end else begin
          e = q.pop_front();
          if (e.val != cur || e.cyc != cyc) begin
            n_err++;
            $display("FAIL update cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, cur, e.val, e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_update cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, cur, e.val, e.cyc);
      end
      prev = cur;
      if (done && q.size() == 0 && rq.size() == 0) break;
      if (cyc > 30000) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout cyc=%0d pending=%0d exp=0", cyc, q.size());
        break;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_input_seq.md
ALU_INPUT_SEQ -- requirements
Module: alu_input_seq

Interface
REQ-001 The block SHALL have one parameter: DB_CYCLES, default 50000, the number of consecutive stable synchronized samples needed to accept a step_btn level change (legal values 2..65535).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 sw  input  4  raw switch value, asynchronous to clk; captured as operand or opcode.
REQ-005 step_btn  input  1  raw push-button, asynchronous and bouncing; each accepted press advances the sequence.
REQ-006 clr  input  1  synchronous clear, already clean and in the clk domain, level-sensitive.
REQ-007 a  output  4  operand A to the ALU, registered.
REQ-008 b  output  4  operand B to the ALU, registered.
REQ-009 op  output  3  ALU opcode, registered.
REQ-010 op_valid  output  1  high only while a, b and op form a complete committed operation.
REQ-011 phase  output  2  current FSM state for LED display, registered.

Function
REQ-012 The block SHALL pass step_btn and sw through two-flop synchronizers before any use.
REQ-013 Debounce SHALL work as follows:
- a counter increments each cycle while the synchronized button differs from the stable level;
- the counter clears on any cycle where they match;
- the stable level SHALL toggle on the cycle the counter reaches DB_CYCLES-1 while still differing, and the counter SHALL clear then.
REQ-014 A one-cycle press pulse SHALL assert on each 0->1 transition of the stable level, and never on a 1->0 transition.
REQ-015 Latency from a clean raw step_btn rise to the press pulse SHALL be 2+DB_CYCLES cycles.
REQ-016 FSM states and phase encodings SHALL be: S_A=00, S_B=01, S_OP=10, S_RUN=11.
REQ-017 On each press, the FSM SHALL act on the synchronized sw value present in the press cycle:
- S_A: a<=sw, go to S_B;
- S_B: b<=sw, go to S_OP;
- S_OP: op<=sw[2:0], go to S_RUN;
- S_RUN: go to S_A.
REQ-018 Updates to a, b, op and phase SHALL appear one clock after the press pulse.
REQ-019 a, b and op SHALL hold their values in every state until rewritten or cleared.
REQ-020 op_valid SHALL equal (state==S_RUN), asserting in the same cycle op updates.
REQ-021 clr SHALL take priority over a simultaneous press:
- a, b and op go to 0;
- state goes to S_A and op_valid to 0;
- debounce state is unaffected.
REQ-022 sw[3] SHALL be ignored in S_OP.
REQ-023 The debounce counter SHALL saturate and never wrap.
REQ-024 A bounce shorter than DB_CYCLES SHALL produce no press.

Reset
REQ-025 Asserting rst SHALL immediately, with no clock required, force:
- a=0, b=0, op=0, op_valid=0, phase=00;
- synchronizer flops, stable level and counter to 0.
REQ-026 Reset asserted mid-sequence SHALL discard any partial entry.
REQ-027 Reset release SHALL be usable on any edge.
REQ-028 A button held through reset release SHALL yield exactly one press, 2+DB_CYCLES cycles after release.

Structure
REQ-029 FSM state encodings and ALU opcode constants SHALL live in the shared ALU package or header, also used by the ALU and bench.
REQ-030 Debounce and edge detection SHALL be one sub-module, btn_debounce, parameterized by DB_CYCLES and outputting the press pulse.
REQ-031 The FSM and operand registers SHALL live in alu_input_seq.

Verification (DB_CYCLES=4)
REQ-032 Scenario 1, full entry:
- stimulus: presses with sw=3, then 5, then 4'b0001;
- response: a=3, b=5, op=1, op_valid=1, phase=11;
- response: one further press gives op_valid=0, phase=00, while a, b and op hold.
REQ-033 Scenario 2, bounce: toggle step_btn every 2 cycles for 20 cycles, then hold high -> exactly one press, 6 cycles after the final rise.
REQ-034 Scenario 3, clear priority: clr and press in the same cycle while in S_OP -> a=b=op=0, phase=00, op not loaded.
REQ-035 Scenario 4, async reset mid-sequence: rst pulsed between clock edges in S_B -> outputs 0 before the next edge; the next entry starts at S_A.
REQ-036 Scenario 5, opcode masking: sw=4'b1110 in S_OP -> op=3'b110.
REQ-037 Scenario 6, held button: step_btn held high through reset release -> a single press at cycle 6 after release; no further presses while held.
